// File: rtl/panel_input_conditioner_pkg.sv
// ============================================================================
// panel_input_pkg: shared state encoding and default timing constants, rev 1.0
// ============================================================================
`default_nettype none

package panel_input_pkg;

   typedef enum logic [0:0] {
      STABLE   = 1'b0,
      SETTLING = 1'b1
   } deb_state_t;

   localparam int DEFAULT_WIDTH           = 9;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
   localparam int DEFAULT_HOLD_CYCLES     = 2000000;

endpackage

`default_nettype wire

// File: rtl/panel_input_conditioner_if.sv
// ============================================================================
// panel_input_conditioner_if: raw pins in, conditioned levels/pulses out, rev 1.0
// ============================================================================
`default_nettype none

interface panel_input_conditioner_if
   import panel_input_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic [WIDTH-1:0] raw_in;
   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;
   logic             hold_pulse;
   logic             any_change;

   modport master (
      output raw_in,
      input  level, rise_pulse, fall_pulse, hold_pulse, any_change
   );

   modport slave (
      input  raw_in,
      output level, rise_pulse, fall_pulse, hold_pulse, any_change
   );
endinterface

`default_nettype wire

// File: rtl/panel_input_conditioner_debounce_channel.sv
// ============================================================================
// debounce_channel: 2-flop sync, debounce counter/FSM and edge pulses, rev 1.0
// ============================================================================
`default_nettype none

module debounce_channel
   import panel_input_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic clock,
   input  logic reset_pulse,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic toggle_next
);
   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_meta;
   logic             sync_q;
   logic             mismatch;
   deb_state_t       state;
   deb_state_t       state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   assign mismatch = sync_q ^ level;

   // The cycle that enters SETTLING is already the first mismatching sample.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      toggle_next = 1'b0;
      case (state)
         STABLE: begin
            if (mismatch) begin
               state_next = SETTLING;
               cnt_next   = CNT_W'(1);
            end
         end
         SETTLING: begin
            if (!mismatch) begin
               state_next = STABLE;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next  = STABLE;
               cnt_next    = '0;
               toggle_next = 1'b1;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_next = STABLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_pulse) begin
      if (!reset_pulse) begin
         sync_meta <= RESET_LEVEL;
         sync_q    <= RESET_LEVEL;
         level     <= RESET_LEVEL;
         rise      <= 1'b0;
         fall      <= 1'b0;
         state     <= STABLE;
         cnt       <= '0;
      end else begin
         sync_meta <= raw;
         sync_q    <= sync_meta;
         state     <= state_next;
         cnt       <= cnt_next;
         level     <= level ^ toggle_next;
         rise      <= toggle_next & ~level;
         fall      <= toggle_next & level;
      end
   end

endmodule

`default_nettype wire

// File: rtl/panel_input_conditioner.sv
// ============================================================================
// panel_input_conditioner: per-channel debounce plus long-press on bit 0, rev 1.0
// ============================================================================
`default_nettype none

module panel_input_conditioner
   import panel_input_pkg::*;
#(
   parameter int               WIDTH           = DEFAULT_WIDTH,
   parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int               HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
   parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
   input logic                       clock,
   input logic                       reset_pulse,
   panel_input_conditioner_if.slave  bus
);
   localparam int               HOLD_W    = $clog2(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic [WIDTH-1:0]  toggle_next;
   logic [HOLD_W-1:0] hold_cnt;
   logic              hold_done;

   genvar gi;
   for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (RESET_LEVEL[gi])
      ) u_chan (
         .clock       (clock),
         .reset_pulse (reset_pulse),
         .raw         (bus.raw_in[gi]),
         .level       (bus.level[gi]),
         .rise        (bus.rise_pulse[gi]),
         .fall        (bus.fall_pulse[gi]),
         .toggle_next (toggle_next[gi])
      );
   end

   // Counter is zero whenever level[0] is low, so an accepted rise always
   // starts a fresh count; hold_done latches so a long hold fires only once.
   always_ff @(posedge clock or negedge reset_pulse) begin
      if (!reset_pulse) begin
         hold_cnt       <= '0;
         hold_done      <= 1'b0;
         bus.hold_pulse <= 1'b0;
         bus.any_change <= 1'b0;
      end else begin
         bus.any_change <= |toggle_next;
         bus.hold_pulse <= 1'b0;
         if (!bus.level[0]) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
         end else if (!hold_done) begin
            if (hold_cnt == HOLD_LAST) begin
               bus.hold_pulse <= 1'b1;
               hold_done      <= 1'b1;
            end else begin
               hold_cnt <= hold_cnt + HOLD_W'(1);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_panel_input_conditioner.sv
// ============================================================================
// tb_panel_input_conditioner: directed + random checks against a window model, rev 1.0
// ============================================================================
`default_nettype none

module tb_panel_input_conditioner;
   localparam int             W  = 9;
   localparam int             D  = 4;
   localparam int             H  = 16;
   localparam logic [W-1:0]   RL = 9'h1F0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   panel_input_conditioner_if #(.WIDTH(W)) bus ();

   panel_input_conditioner #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .HOLD_CYCLES     (H),
      .RESET_LEVEL     (RL)
   ) dut (
      .clock       (clk),
      .reset_pulse (rst_n),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Reference: a level flips once the last D synchronized samples all
   // disagree with it; hold fires H edges after an accepted rise of bit 0.
   logic [W-1:0] m_s1, m_s2, m_level, m_rise, m_fall;
   logic [W-1:0] m_win [D];
   logic         m_any, m_hold;
   bit           m_armed;
   bit           settled;
   int           m_edge = 0;
   int           m_rise_edge = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = RL; m_s2 = RL; m_level = RL;
         for (int k = 0; k < D; k++) m_win[k] = RL;
         m_rise = '0; m_fall = '0; m_any = 1'b0; m_hold = 1'b0; m_armed = 1'b0;
      end else begin
         m_edge++;
         m_hold = m_armed && (m_edge == m_rise_edge + H);
         for (int k = D - 1; k > 0; k--) m_win[k] = m_win[k-1];
         m_win[0] = m_s2;
         m_s2 = m_s1;
         m_s1 = bus.raw_in;
         m_rise = '0; m_fall = '0;
         for (int c = 0; c < W; c++) begin
            settled = 1'b1;
            for (int k = 0; k < D; k++) if (m_win[k][c] == m_level[c]) settled = 1'b0;
            if (settled) begin
               if (m_level[c]) m_fall[c] = 1'b1; else m_rise[c] = 1'b1;
               m_level[c] = ~m_level[c];
            end
         end
         m_any = |(m_rise | m_fall);
         if (m_rise[0]) begin m_armed = 1'b1; m_rise_edge = m_edge; end
         if (m_fall[0]) m_armed = 1'b0;
      end
   end

   wire  [3*W+1:0] dut_v = {bus.level, bus.rise_pulse, bus.fall_pulse, bus.any_change, bus.hold_pulse};
   logic [3*W+1:0] mdl_v;
   assign mdl_v = {m_level, m_rise, m_fall, m_any, m_hold};

   task automatic test_reset();
      rst_n = 1'b0;
      bus.raw_in = RL;
      repeat (2) @(negedge clk);
      total++;
      if (dut_v !== {RL, {(2*W+2){1'b0}}}) begin
         bad++; $display("FAIL reset_state: got %h expected %h", dut_v, {RL, {(2*W+2){1'b0}}});
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         total++;
         if ((bus.rise_pulse | bus.fall_pulse) !== '0 || bus.level !== RL) begin
            bad++; $display("FAIL reset_release e%0d: got lvl=%h r=%h f=%h expected lvl=%h no pulses",
                            e, bus.level, bus.rise_pulse, bus.fall_pulse, RL);
         end
         total++;
         if (dut_v !== mdl_v) begin bad++; $display("FAIL reset_model: got %h expected %h", dut_v, mdl_v); end
      end
   endtask

   task automatic test_clean_press();
      logic [2:0] got, want;
      bus.raw_in[0] = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         @(negedge clk);
         total++;
         if (dut_v !== mdl_v) begin bad++; $display("FAIL press_model e%0d: got %h expected %h", e, dut_v, mdl_v); end
         if (e >= 5 && e <= 7) begin
            got  = {bus.level[0], bus.rise_pulse[0], bus.any_change};
            want = (e == 5) ? 3'b000 : (e == 6) ? 3'b111 : 3'b100;
            total++;
            if (got !== want) begin bad++; $display("FAIL press_edge e%0d: got %b expected %b", e, got, want); end
         end
      end
      bus.raw_in[0] = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         total++;
         if (dut_v !== mdl_v) begin bad++; $display("FAIL press_release: got %h expected %h", dut_v, mdl_v); end
      end
   endtask

   task automatic test_glitch();
      int seen, rises, rise_e;
      seen = 0;
      bus.raw_in[3] = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         if (e == 4) bus.raw_in[3] = 1'b0;
         @(negedge clk);
         if (bus.level[3] || bus.rise_pulse[3]) seen++;
         total++;
         if (dut_v !== mdl_v) begin bad++; $display("FAIL glitch_model e%0d: got %h expected %h", e, dut_v, mdl_v); end
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL glitch_reject: got %0d high cycles expected 0", seen); end
      rises = 0; rise_e = 0;
      bus.raw_in[3] = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         if (e == 5) bus.raw_in[3] = 1'b0;
         @(negedge clk);
         if (bus.rise_pulse[3]) begin rises++; rise_e = e; end
         total++;
         if (dut_v !== mdl_v) begin bad++; $display("FAIL accept4_model e%0d: got %h expected %h", e, dut_v, mdl_v); end
      end
      total++;
      if (rises !== 1 || rise_e !== 6) begin
         bad++; $display("FAIL accept4_rise: got %0d pulses at e%0d expected 1 at e6", rises, rise_e);
      end
   endtask

   task automatic test_bounce();
      int falls, fall_e;
      bus.raw_in[0] = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         total++;
         if (dut_v !== mdl_v) begin bad++; $display("FAIL bounce_pre: got %h expected %h", dut_v, mdl_v); end
      end
      falls = 0; fall_e = 0;
      for (int t = 0; t < 10; t++) begin
         bus.raw_in[0] = (t % 2 == 1);
         @(negedge clk);
         if (bus.fall_pulse[0]) falls++;
         total++;
         if (dut_v !== mdl_v) begin bad++; $display("FAIL bounce_model t%0d: got %h expected %h", t, dut_v, mdl_v); end
      end
      bus.raw_in[0] = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         if (bus.fall_pulse[0]) begin falls++; fall_e = e; end
         total++;
         if (dut_v !== mdl_v) begin bad++; $display("FAIL settle_model e%0d: got %h expected %h", e, dut_v, mdl_v); end
      end
      total++;
      if (falls !== 1 || fall_e !== 6) begin
         bad++; $display("FAIL bounce_fall: got %0d pulses at e%0d expected 1 at e6", falls, fall_e);
      end
   endtask

   task automatic test_long_press();
      int holds, hold_e, rise_e;
      holds = 0; hold_e = 0; rise_e = 0;
      bus.raw_in[0] = 1'b1;
      for (int e = 1; e <= 70; e++) begin
         @(negedge clk);
         if (bus.rise_pulse[0]) rise_e = e;
         if (bus.hold_pulse) begin holds++; hold_e = e; end
         total++;
         if (dut_v !== mdl_v) begin bad++; $display("FAIL long_model e%0d: got %h expected %h", e, dut_v, mdl_v); end
      end
      total++;
      if (holds !== 1 || rise_e !== 6 || hold_e !== 6 + H) begin
         bad++; $display("FAIL long_hold: got %0d holds rise e%0d hold e%0d expected 1 rise e6 hold e%0d",
                         holds, rise_e, hold_e, 6 + H);
      end
      bus.raw_in[0] = 1'b0;
      repeat (10) @(negedge clk);
      holds = 0;
      bus.raw_in[0] = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         if (e == 11) bus.raw_in[0] = 1'b0;
         @(negedge clk);
         if (bus.hold_pulse) holds++;
         total++;
         if (dut_v !== mdl_v) begin bad++; $display("FAIL short_model e%0d: got %h expected %h", e, dut_v, mdl_v); end
      end
      total++;
      if (holds !== 0) begin bad++; $display("FAIL short_hold: got %0d holds expected 0", holds); end
   endtask

   task automatic test_simultaneous();
      logic [2:0] got, want;
      bus.raw_in[8:7] = 2'b00;
      repeat (10) @(negedge clk);
      bus.raw_in[8:7] = 2'b11;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         total++;
         if (dut_v !== mdl_v) begin bad++; $display("FAIL simul_model e%0d: got %h expected %h", e, dut_v, mdl_v); end
         if (e == 6 || e == 7) begin
            got  = {bus.rise_pulse[8], bus.rise_pulse[7], bus.any_change};
            want = (e == 6) ? 3'b111 : 3'b000;
            total++;
            if (got !== want) begin bad++; $display("FAIL simul_edge e%0d: got %b expected %b", e, got, want); end
         end
      end
   endtask

   task automatic test_reset_abort();
      bus.raw_in[1] = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (bus.level !== RL) begin bad++; $display("FAIL abort_in_reset: got %h expected %h", bus.level, RL); end
      rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         total++;
         if (dut_v !== mdl_v) begin bad++; $display("FAIL abort_model e%0d: got %h expected %h", e, dut_v, mdl_v); end
         if (e == 5 || e == 6) begin
            total++;
            if ({bus.level[1], bus.rise_pulse[1]} !== ((e == 6) ? 2'b11 : 2'b00)) begin
               bad++; $display("FAIL abort_relatch e%0d: got %b%b expected %0s", e,
                               bus.level[1], bus.rise_pulse[1], (e == 6) ? "11" : "00");
            end
         end
      end
      bus.raw_in[1] = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_random();
      logic [W-1:0] r;
      r = bus.raw_in;
      for (int c = 0; c < 800; c++) begin
         for (int b = 0; b < W; b++)
            if ($urandom_range(0, (b == 0) ? 39 : 5) == 0) r[b] = ~r[b];
         bus.raw_in = r;
         rst_n = ($urandom_range(0, 249) != 0);
         @(negedge clk);
         total++;
         if (dut_v !== mdl_v) begin bad++; $display("FAIL random c%0d: got %h expected %h", c, dut_v, mdl_v); end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      bus.raw_in = RL;
      test_reset();
      test_clean_press();
      test_glitch();
      test_bounce();
      test_long_press();
      test_simultaneous();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/panel_input_conditioner.md
# panel_input_conditioner

Conditions the raw panel inputs (push button, selector, water-level and state switches, sprinkler/dripper switches) before they reach the FSMs and the display logic. Each channel is synchronized, debounced and edge-detected. Channel 0 (the push button) also gets long-press detection. The block sits between the board pins and the water-tank / irrigation FSMs on the fast clock domain. It is the input-side counterpart of the matrix/column output drivers.

## Interface

- `WIDTH`, default 9: number of input channels. Bit 0 is the push button; higher bits are the switches.
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive stable synchronized cycles required to accept a new level. Must be ≥ 2.
- `HOLD_CYCLES`, default 2000000: cycles channel 0 must stay high after its accepted rise before `hold_pulse` fires. Must be > `DEBOUNCE_CYCLES`.
- `RESET_LEVEL`, default all-zero, `WIDTH` bits: level loaded into all channel state at reset.
- `clock`  in  1  the single clock (fast_clock in the top level); all state is on its rising edge.
- `reset_pulse`  in  1  reset: asynchronous and active-low.
- `raw_in`  in  WIDTH  asynchronous pin levels, already polarity-corrected so that 1 = active.
- `level`  out  WIDTH  debounced stable level per channel.
- `rise_pulse`  out  WIDTH  one-cycle pulse when `level[i]` goes 0→1.
- `fall_pulse`  out  WIDTH  one-cycle pulse when `level[i]` goes 1→0.
- `hold_pulse`  out  1  one-cycle pulse when channel 0 has been accepted-high for `HOLD_CYCLES`.
- `any_change`  out  1  OR of all `rise_pulse` and `fall_pulse` bits, registered in the same cycle as the pulses.

## Operation

- Per channel: a 2-flop synchronizer, then a debounce counter, then a two-state FSM.
- FSM states:
  - STABLE: the synchronized value equals `level`. Counter is held at 0.
  - SETTLING: the synchronized value differs from `level`. The counter increments each cycle.
- Transitions:
  - STABLE→SETTLING on the first mismatch.
  - SETTLING→STABLE, counter cleared and `level` unchanged, if the synchronized value returns to `level` (a glitch is rejected).
  - SETTLING→STABLE with `level` toggled when the counter reaches `DEBOUNCE_CYCLES-1` and the mismatch is still present.
- `rise_pulse`/`fall_pulse` are asserted for exactly one cycle, registered alongside the `level` update.
- Counter width is clog2(`DEBOUNCE_CYCLES`). It saturates and never wraps.
- Hold logic (channel 0 only):
  - The hold counter clears on `rise_pulse[0]` and counts while `level[0]`=1.
  - `hold_pulse` fires once when the count reaches `HOLD_CYCLES-1`. The counter then stops; holding longer never repeats the pulse.
  - `level[0]` falling before the threshold clears the counter with no pulse.
- Channels are independent. Simultaneous changes on several channels each produce their own pulses in the same cycle.
- At reset:
  - Synchronizer flops and `level` load `RESET_LEVEL`, so no edge is reported at reset release.
  - Counters load 0, FSMs load STABLE.
  - All pulse outputs and `any_change` load 0.

## Timing

- If `raw_in[i]` changes between edges 0 and 1 and then holds, `level[i]` and its pulse update at edge 2+`DEBOUNCE_CYCLES`. The pulse deasserts at the following edge.
- Any mismatch run shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.
- `hold_pulse` asserts at `HOLD_CYCLES` edges after the edge that asserted `rise_pulse[0]`.
- Asserting reset mid-SETTLING or mid-hold aborts immediately. After release, a still-different input needs a full `2+DEBOUNCE_CYCLES` again.
- No combinational path from `raw_in` to any output.

## Structure

- Shared package `panel_input_pkg`:
  - FSM state enum (STABLE, SETTLING).
  - Default constants for `DEBOUNCE_CYCLES` and `HOLD_CYCLES`, so the top level and testbench share them.
- One natural sub-module, `debounce_channel`: synchronizer + counter + FSM + edge pulses for one bit, instantiated `WIDTH` times by generate.
- The hold counter and `any_change` OR-reduction live in the parent.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=16 and `WIDTH`=9.

- Clean press: `raw_in[0]` 0→1 held → `level[0]`=1 and `rise_pulse[0]`=1 for one cycle at edge 6; `any_change`=1 the same cycle; other bits stay 0.
- Glitch reject: `raw_in[3]` high for 3 cycles then low → `level[3]` stays 0, no pulses. A 4-cycle synchronized high run instead → `rise_pulse[3]`.
- Release and bounce: `raw_in[0]` toggles every cycle for 10 cycles then settles at 0 from `level`=1 → exactly one `fall_pulse[0]`, 6 edges after settling.
- Long press: `raw_in[0]` held high → `hold_pulse` once at 16 edges after `rise_pulse[0]`; 40 more held cycles produce no repeat. A release after 10 cycles produces no `hold_pulse`.
- Simultaneous: `raw_in[8:7]` both 0→1 on the same edge → `rise_pulse[8]` and `rise_pulse[7]` in the same cycle; `any_change` high for one cycle.
- Reset: `RESET_LEVEL`=9'h1F0 with the inputs matching it → no pulses after release. Reset asserted at SETTLING count 2 → after release, a full 6 edges are needed before `level` changes.
